// File: rtl/ccff_pkg.sv
// Shared constants for the configuration-chain loader: FSM encodings,
// CRC-8 polynomial and the words-per-pass helper.
package ccff_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   function automatic int words_per_pass(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 (MSB-first register, poly from ccff_pkg, init 0x00).
// The clear input has priority over the enable.
module ccff_crc8_serial
   import ccff_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       bit_i,
   output logic [7:0] crc_o
);

   logic [7:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb    = crc_q[7] ^ bit_i;
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = 8'h00;
      end else if (en_i) begin
         crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= 8'h00;
      else        crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words into a CCFF configuration chain and optionally
// re-shifts them to verify the chain. Optional CRC output: CCFF_CHAIN_LOADER_CRC_EN.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = 18,
   parameter int WORD_W    = 8,
   parameter int IDX_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              start,
   input  logic              verify,
   input  logic              abort,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              config_enable,
   output logic              config_readback,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [IDX_W-1:0]  err_idx,
`ifdef CCFF_CHAIN_LOADER_CRC_EN
   output logic [7:0]        crc_out,
`endif
   output logic [1:0]        dbg_state
);

   localparam int WORDS = words_per_pass(CHAIN_LEN, WORD_W);
   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam int WC_W  = $clog2(WORDS + 1);

   logic [1:0]        state_q, state_d;
   logic              mode_q, mode_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [IDX_W-1:0]  shifted_q, shifted_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic              err_q, err_d;
   logic [IDX_W-1:0]  err_idx_q, err_idx_d;
   logic              crc_clr;
   logic              in_shift, last_bit, final_bit, hs;

   function automatic logic [CNT_W-1:0] bits_for(input logic [IDX_W-1:0] done_bits);
      int remain;
      remain = CHAIN_LEN - int'(done_bits);
      if (remain > WORD_W) remain = WORD_W;
      return CNT_W'(remain);
   endfunction

   // Stream handshake: a word transfers on a prog_clk edge where s_valid and
   // s_ready are both high; s_ready is registered-decoded and never waits on s_valid.
   assign in_shift  = (state_q == ST_SHIFT);
   assign last_bit  = in_shift && (bit_cnt_q == CNT_W'(1));
   assign final_bit = in_shift && (shifted_q == IDX_W'(CHAIN_LEN - 1));
   assign s_ready   = (state_q == ST_FETCH) ||
                      (last_bit && !final_bit && (word_cnt_q < WC_W'(WORDS)));
   assign hs        = s_valid && s_ready;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      shreg_d    = shreg_q;
      shifted_d  = shifted_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      err_d      = err_q;
      err_idx_d  = err_idx_q;
      crc_clr    = 1'b0;

      // The chain shifts on every edge with config_enable high, abort or not.
      if (in_shift && mode_q && (ccff_tail != shreg_q[0]) && !err_q) begin
         err_d     = 1'b1;
         err_idx_d = shifted_q;
      end

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d    = ST_FETCH;
                  mode_d     = verify;
                  err_d      = 1'b0;
                  err_idx_d  = '0;
                  shifted_d  = '0;
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
                  crc_clr    = 1'b1;
               end
            end
            ST_FETCH: begin
               if (hs) begin
                  shreg_d    = s_data;
                  bit_cnt_d  = bits_for(shifted_q);
                  word_cnt_d = word_cnt_q + WC_W'(1);
                  state_d    = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               shreg_d   = shreg_q >> 1;
               shifted_d = shifted_q + IDX_W'(1);
               bit_cnt_d = bit_cnt_q - CNT_W'(1);
               if (final_bit) begin
                  state_d = ST_DONE;
               end else if (last_bit) begin
                  if (hs) begin
                     shreg_d    = s_data;
                     bit_cnt_d  = bits_for(shifted_q + IDX_W'(1));
                     word_cnt_d = word_cnt_q + WC_W'(1);
                  end else begin
                     state_d = ST_FETCH;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= 1'b0;
         shreg_q    <= '0;
         shifted_q  <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         err_q      <= 1'b0;
         err_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         shreg_q    <= shreg_d;
         shifted_q  <= shifted_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         err_q      <= err_d;
         err_idx_q  <= err_idx_d;
      end
   end

   assign config_enable   = in_shift;
   assign ccff_head       = in_shift & shreg_q[0];
   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);
   assign config_readback = busy & mode_q;
   assign err             = err_q;
   assign err_idx         = err_idx_q;
   assign dbg_state       = state_q;

`ifdef CCFF_CHAIN_LOADER_CRC_EN
   ccff_crc8_serial u_crc (
      .clk   (prog_clk),
      .rst_n (pReset_n),
      .clr_i (crc_clr),
      .en_i  (config_enable),
      .bit_i (ccff_head),
      .crc_o (crc_out)
   );
`else
   logic unused_crc_clr;
   assign unused_crc_clr = crc_clr;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with an 18-flop chain model at the head/tail.
// Define CCFF_CHAIN_LOADER_CRC_EN to also check crc_out.
module tb_ccff_chain_loader;

   localparam int CHAIN_LEN = 18;
   localparam int WORD_W    = 8;
   localparam int IDX_W     = 5;
   localparam logic [17:0] EXP_IMG = 18'h23CA5;  // {0x02[1:0], 0x3C, 0xA5}
   localparam logic [17:0] BAD_IMG = 18'h23DA5;  // word 1 = 0x3D

   logic              prog_clk = 1'b0;
   logic              pReset_n = 1'b0;
   logic              start = 1'b0;
   logic              verify = 1'b0;
   logic              abort = 1'b0;
   logic [WORD_W-1:0] s_data = '0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic              ccff_head;
   logic              ccff_tail;
   logic              config_enable;
   logic              config_readback;
   logic              busy;
   logic              done;
   logic              err;
   logic [IDX_W-1:0]  err_idx;
   logic [1:0]        dbg_state;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
   logic [7:0]        crc_out;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int en_cnt, gap_cnt, done_cnt, rb_bad;

   // Chain model: head enters at bit 17, bit 0 feeds ccff_tail.
   logic [17:0] chain = '0;
   always @(posedge prog_clk) if (config_enable) chain <= {ccff_head, chain[17:1]};
   assign ccff_tail = chain[0];

   always #5 prog_clk = ~prog_clk;

   ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .IDX_W(IDX_W)) dut (
      .prog_clk        (prog_clk),
      .pReset_n        (pReset_n),
      .start           (start),
      .verify          (verify),
      .abort           (abort),
      .s_data          (s_data),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .ccff_head       (ccff_head),
      .ccff_tail       (ccff_tail),
      .config_enable   (config_enable),
      .config_readback (config_readback),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .err_idx         (err_idx),
`ifdef CCFF_CHAIN_LOADER_CRC_EN
      .crc_out         (crc_out),
`endif
      .dbg_state       (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] crc_ref(input logic [17:0] img);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      for (int i = 0; i < 18; i++) begin
         fb = c[7] ^ img[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_s_ready"}, s_ready, 0);
      check({tag, "_head"}, ccff_head, 0);
      check({tag, "_cfg_en"}, config_enable, 0);
      check({tag, "_readback"}, config_readback, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_err_idx"}, err_idx, 0);
   endtask

   // One pass driven from negedge to negedge; counters collected at each negedge.
   task automatic run_pass(input logic vmode, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input int stall_n, input int abort_at,
                           input int reset_at);
      logic [7:0] words [3];
      int idx, stall_left;
      bit ended;
      words[0] = w0; words[1] = w1; words[2] = w2;
      idx = 0; stall_left = stall_n; ended = 0;
      en_cnt = 0; gap_cnt = 0; done_cnt = 0; rb_bad = 0;
      @(negedge prog_clk);
      start = 1'b1; verify = vmode;
      @(negedge prog_clk);
      start = 1'b0; verify = 1'b0;
`ifdef CCFF_CHAIN_LOADER_CRC_EN
      check("crc_clr_on_start", crc_out, 0);
`endif
      for (int cyc = 0; cyc < 300 && !ended; cyc++) begin
         abort = 1'b0;
         if (config_enable) en_cnt++;
         else if (busy && en_cnt > 0 && en_cnt < CHAIN_LEN) gap_cnt++;
         if (done) done_cnt++;
         if (busy && config_readback !== vmode) rb_bad++;
         if (!busy) begin
            ended = 1;
         end else if (reset_at >= 0 && en_cnt == reset_at) begin
            #2 pReset_n = 1'b0;
            #1 check_idle_outputs("async_rst");
            ended = 1;
         end else begin
            if (abort_at >= 0 && en_cnt == abort_at) abort = 1'b1;
            if (idx == 1 && stall_left > 0) begin
               s_valid = 1'b0;
               if (s_ready) stall_left--;
            end else if (idx < 3) begin
               s_valid = 1'b1;
               s_data  = words[idx];
               if (s_ready) idx++;
            end else begin
               s_valid = 1'b0;
            end
            @(negedge prog_clk);
         end
      end
      abort = 1'b0;
      s_valid = 1'b0;
      check("pass_terminated", ended, 1);
   endtask

   initial begin
      repeat (3) @(negedge prog_clk);
      check_idle_outputs("reset");
      pReset_n = 1'b1;
      @(negedge prog_clk);

      // Plain load, no stalls
      run_pass(1'b0, 8'hA5, 8'h3C, 8'h02, 0, -1, -1);
      check("load_en_cycles", en_cnt, 18);
      check("load_en_gap", gap_cnt, 0);
      check("load_done_pulses", done_cnt, 1);
      check("load_readback", rb_bad, 0);
      check("load_err", err, 0);
      check("load_image", chain, EXP_IMG);
`ifdef CCFF_CHAIN_LOADER_CRC_EN
      check("load_crc", crc_out, crc_ref(EXP_IMG));
      repeat (4) @(negedge prog_clk);
      check("load_crc_hold", crc_out, crc_ref(EXP_IMG));
`endif

      // Verify with matching data
      run_pass(1'b1, 8'hA5, 8'h3C, 8'h02, 0, -1, -1);
      check("vfy_en_cycles", en_cnt, 18);
      check("vfy_done_pulses", done_cnt, 1);
      check("vfy_readback", rb_bad, 0);
      check("vfy_err", err, 0);
      check("vfy_image", chain, EXP_IMG);

      // Verify with a corrupted word 1
      run_pass(1'b1, 8'hA5, 8'h3D, 8'h02, 0, -1, -1);
      check("bad_en_cycles", en_cnt, 18);
      check("bad_done_pulses", done_cnt, 1);
      check("bad_err", err, 1);
      check("bad_err_idx", err_idx, 8);
      check("bad_image", chain, BAD_IMG);

      // Abort and start together in IDLE: stay idle, err untouched
      @(negedge prog_clk);
      start = 1'b1; abort = 1'b1; verify = 1'b0;
      @(negedge prog_clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", busy, 0);
      check("abort_start_err", err, 1);
      check("abort_start_err_idx", err_idx, 8);

      // Load with a 5-cycle stall before word 1
      run_pass(1'b0, 8'hA5, 8'h3C, 8'h02, 5, -1, -1);
      check("stall_en_cycles", en_cnt, 18);
      check("stall_en_gap", gap_cnt, 5);
      check("stall_done_pulses", done_cnt, 1);
      check("stall_err_cleared", err, 0);
      check("stall_image", chain, EXP_IMG);

      // Reset at shift 10, then a fresh load
      run_pass(1'b0, 8'h5A, 8'hC3, 8'h01, 0, -1, 10);
      check("rst_done_pulses", done_cnt, 0);
      @(negedge prog_clk);
      pReset_n = 1'b1;
      @(negedge prog_clk);
      run_pass(1'b0, 8'hA5, 8'h3C, 8'h02, 0, -1, -1);
      check("reload_en_cycles", en_cnt, 18);
      check("reload_done_pulses", done_cnt, 1);
      check("reload_image", chain, EXP_IMG);

      // Abort at shift 4
      run_pass(1'b0, 8'hA5, 8'h3C, 8'h02, 0, 4, -1);
      check("abort_en_cycles", en_cnt, 4);
      check("abort_done_pulses", done_cnt, 0);
      check("abort_busy", busy, 0);
      check("abort_state", dbg_state, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
